// File: rtl/write_data_if.sv
// Symbol-receive / memory-write bus for write_data.
// The master drives the symbol stream; the slave (write_data) drives the memory-write side.
interface write_data_if;
  logic        load_w;
  logic        rx_en;
  logic [1:0]  in;
  logic [2:0]  cnt_8;
  logic [15:0] data_w;
  logic        we_h;
  logic [1:0]  add_h;
  logic        we_s;
  logic [3:0]  add_s;
  logic        add_colS;
  logic        busy;
  logic        done_w;
  logic        err;

  modport master (
    output load_w, rx_en, in,
    input  cnt_8, data_w, we_h, add_h, we_s, add_s, add_colS, busy, done_w, err
  );

  modport slave (
    input  load_w, rx_en, in,
    output cnt_8, data_w, we_h, add_h, we_s, add_s, add_colS, busy, done_w, err
  );
endinterface

// File: rtl/write_data.sv
// Packs 2-bit received symbols into 16-bit words and writes one frame into H then S memory.
// Optional macro WRITE_DATA_PARITY_EN: each word is followed by an XOR check symbol.
module write_data #(
  parameter int H_DEPTH = 4,
  parameter int S_DEPTH = 16,
  parameter int N_COL   = 2
) (
  input logic         clk,
  input logic         rst,
  write_data_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, WR_H = 2'd1, WR_S = 2'd2, DONE = 2'd3} state_t;

  localparam logic [1:0] H_LAST = 2'(H_DEPTH - 1);
  localparam logic [3:0] S_LAST = 4'(S_DEPTH - 1);
  localparam logic       C_LAST = 1'(N_COL - 1);

`ifdef WRITE_DATA_PARITY_EN
  function automatic logic [1:0] sym_xor(input logic [15:0] w);
    logic [1:0] x;
    x = 2'b00;
    for (int i = 0; i < 8; i++) begin
      x = x ^ w[2*i +: 2];
    end
    return x;
  endfunction
`endif

  state_t      state_q, state_d;
  logic [15:0] sr_q, sr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] data_q, data_d;
  logic        we_h_q, we_h_d;
  logic        we_s_q, we_s_d;
  logic [1:0]  add_h_q, add_h_d;
  logic [3:0]  add_s_q, add_s_d;
  logic        col_q, col_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        chk_q, chk_d;

  // Next-state, packing, strobe and address logic
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    we_h_d  = 1'b0;
    we_s_d  = 1'b0;
    add_h_d = add_h_q;
    add_s_d = add_s_q;
    col_d   = col_q;
    err_d   = err_q;
    chk_d   = chk_q;

    case (state_q)
      IDLE: begin
        if (bus.load_w) begin
          state_d = WR_H;
          cnt_d   = 3'd0;
          add_h_d = 2'd0;
          add_s_d = 4'd0;
          col_d   = 1'b0;
          err_d   = 1'b0;
          chk_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      WR_H, WR_S: begin
        // Addresses move on the edge that ends a strobe, so they are stable while it is high
        if (we_h_q) begin
          if (add_h_q == H_LAST) begin
            state_d = WR_S;
            add_s_d = 4'd0;
            col_d   = 1'b0;
          end else begin
            add_h_d = add_h_q + 2'd1;
          end
        end else if (we_s_q) begin
          if (add_s_q == S_LAST) begin
            add_s_d = 4'd0;
            if (col_q == C_LAST) begin
              state_d = DONE;
            end else begin
              col_d = col_q + 1'b1;
            end
          end else begin
            add_s_d = add_s_q + 4'd1;
          end
        end else begin
          state_d = state_q;
        end

        if (bus.rx_en) begin
`ifdef WRITE_DATA_PARITY_EN
          if (chk_q) begin
            chk_d = 1'b0;
            if (bus.in == sym_xor(sr_q)) begin
              data_d = sr_q;
              we_h_d = (state_q == WR_H);
              we_s_d = (state_q == WR_S);
            end else begin
              err_d = 1'b1;
            end
          end else begin
            sr_d  = {sr_q[13:0], bus.in};
            cnt_d = cnt_q + 3'd1;
            chk_d = (cnt_q == 3'd7);
          end
`else
          sr_d  = {sr_q[13:0], bus.in};
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            data_d = sr_d;
            we_h_d = (state_q == WR_H);
            we_s_d = (state_q == WR_S);
          end else begin
            data_d = data_q;
          end
`endif
        end else begin
          sr_d = sr_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    done_d = (state_d == DONE) && (state_q != DONE);
    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= 16'd0;
      cnt_q   <= 3'd0;
      data_q  <= 16'd0;
      we_h_q  <= 1'b0;
      we_s_q  <= 1'b0;
      add_h_q <= 2'd0;
      add_s_q <= 4'd0;
      col_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      chk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      we_h_q  <= we_h_d;
      we_s_q  <= we_s_d;
      add_h_q <= add_h_d;
      add_s_q <= add_s_d;
      col_q   <= col_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      chk_q   <= chk_d;
    end
  end

  assign bus.cnt_8    = cnt_q;
  assign bus.data_w   = data_q;
  assign bus.we_h     = we_h_q;
  assign bus.add_h    = add_h_q;
  assign bus.we_s     = we_s_q;
  assign bus.add_s    = add_s_q;
  assign bus.add_colS = col_q;
  assign bus.busy     = busy_q;
  assign bus.done_w   = done_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_write_data.sv
// Self-checking bench for write_data: table-driven packing vectors plus a write scoreboard.
module tb_write_data;

  typedef struct packed {
    logic        is_h;
    logic [3:0]  addr;
    logic        col;
    logic [15:0] data;
  } wr_t;

  typedef struct packed {
    logic [7:0][1:0] syms;
    logic [15:0]     exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic sel, load_s, rx_en_s, gap_mode;
  logic [1:0] in_s;

  int err_cnt, chk_cnt;
  int cyc, n_strobe, n_strobe2, done_cnt, done_cnt2, last_st, last_st2;
  logic prev_done, prev_done2;
  wr_t exp_q[$];
  wr_t exp2_q[$];
  logic [15:0] words [36];
  vec_t tbl [6];

  write_data_if bus ();
  write_data_if bus2 ();

  assign bus.load_w  = sel ? 1'b0 : load_s;
  assign bus.rx_en   = sel ? 1'b0 : rx_en_s;
  assign bus.in      = in_s;
  assign bus2.load_w = sel ? load_s : 1'b0;
  assign bus2.rx_en  = sel ? rx_en_s : 1'b0;
  assign bus2.in     = in_s;

  write_data dut (.clk(clk), .rst(rst), .bus(bus));
  write_data #(.H_DEPTH(1), .S_DEPTH(2), .N_COL(1)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    chk_cnt++;
    if (act !== req) begin
      err_cnt++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] outs1();
    return {1'b0, bus.cnt_8, bus.data_w, bus.we_h, bus.add_h, bus.we_s, bus.add_s,
            bus.add_colS, bus.busy, bus.done_w, bus.err};
  endfunction

  function automatic logic [31:0] outs2();
    return {1'b0, bus2.cnt_8, bus2.data_w, bus2.we_h, bus2.add_h, bus2.we_s, bus2.add_s,
            bus2.add_colS, bus2.busy, bus2.done_w, bus2.err};
  endfunction

`ifdef WRITE_DATA_PARITY_EN
  function automatic logic [1:0] sym_xor(input logic [15:0] w);
    logic [1:0] x;
    x = 2'b00;
    for (int i = 0; i < 8; i++) x = x ^ w[2*i +: 2];
    return x;
  endfunction
`endif

  task automatic send_sym(input logic [1:0] s);
    rx_en_s = 1'b1;
    in_s    = s;
    @(posedge clk); #1;
    rx_en_s = 1'b0;
    if (gap_mode) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int k = 0; k < 8; k++) send_sym(w[15-2*k -: 2]);
`ifdef WRITE_DATA_PARITY_EN
    send_sym(sym_xor(w));
`endif
  endtask

  // load_w pulse with a colliding symbol that must not be captured
  task automatic load_pulse();
    load_s  = 1'b1;
    rx_en_s = 1'b1;
    in_s    = 2'd3;
    @(posedge clk); #1;
    load_s  = 1'b0;
    rx_en_s = 1'b0;
  endtask

  task automatic build_exp(input bit which, input int h, input int s, input int n);
    int idx;
    wr_t e;
    idx = 0;
    for (int a = 0; a < h; a++) begin
      e = {1'b1, 4'(a), 1'b0, words[idx]};
      idx++;
      if (which) exp2_q.push_back(e); else exp_q.push_back(e);
    end
    for (int c = 0; c < n; c++) begin
      for (int a = 0; a < s; a++) begin
        e = {1'b0, 4'(a), 1'(c), words[idx]};
        idx++;
        if (which) exp2_q.push_back(e); else exp_q.push_back(e);
      end
    end
  endtask

  task automatic run_default_frame(input string tag);
    int d0, s0;
    build_exp(1'b0, 4, 16, 2);
    d0 = done_cnt;
    s0 = n_strobe;
    load_pulse();
    for (int i = 0; i < 36; i++) begin
      if (i == 10) begin
        load_s = 1'b1;
        @(posedge clk); #1;
        load_s = 1'b0;
      end
      send_word(words[i]);
    end
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_done"}, done_cnt - d0, 1);
    check({tag, "_strobes"}, n_strobe - s0, 36);
    check({tag, "_queue"}, exp_q.size(), 0);
    check({tag, "_busy"}, bus.busy, 0);
  endtask

  initial begin
    int d0, s0;
    err_cnt  = 0; chk_cnt = 0;
    cyc = 0; n_strobe = 0; n_strobe2 = 0; done_cnt = 0; done_cnt2 = 0;
    last_st = 0; last_st2 = 0; prev_done = 1'b0; prev_done2 = 1'b0;
    sel = 1'b0; load_s = 1'b0; rx_en_s = 1'b0; in_s = 2'd0; gap_mode = 1'b0;
    rst = 1'b1;

    // Strobe/done monitor feeding the scoreboards
    fork
      forever begin
        wr_t e;
        @(negedge clk);
        cyc++;
        if (bus.we_h || bus.we_s) begin
          n_strobe++;
          check("strobe_excl", {31'd0, bus.we_h & bus.we_s}, 0);
          if (exp_q.size() == 0) begin
            check("unexpected_strobe", {16'd0, bus.data_w}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("wr_kind", {31'd0, bus.we_h}, {31'd0, e.is_h});
            check("wr_addr", bus.we_h ? {30'd0, bus.add_h} : {28'd0, bus.add_s}, {28'd0, e.addr});
            if (!e.is_h) check("wr_col", {31'd0, bus.add_colS}, {31'd0, e.col});
            check("wr_data", {16'd0, bus.data_w}, {16'd0, e.data});
          end
          last_st = cyc;
        end
        if (bus.done_w) begin
          done_cnt++;
          check("done_latency", cyc - last_st, 1);
        end
        if (prev_done) check("busy_drop", {31'd0, bus.busy}, 0);
        prev_done = bus.done_w;

        if (bus2.we_h || bus2.we_s) begin
          n_strobe2++;
          if (exp2_q.size() == 0) begin
            check("unexpected_strobe2", {16'd0, bus2.data_w}, 32'hFFFF_FFFF);
          end else begin
            e = exp2_q.pop_front();
            check("wr2_kind", {31'd0, bus2.we_h}, {31'd0, e.is_h});
            check("wr2_addr", bus2.we_h ? {30'd0, bus2.add_h} : {28'd0, bus2.add_s}, {28'd0, e.addr});
            if (!e.is_h) check("wr2_col", {31'd0, bus2.add_colS}, {31'd0, e.col});
            check("wr2_data", {16'd0, bus2.data_w}, {16'd0, e.data});
          end
          last_st2 = cyc;
        end
        if (bus2.done_w) begin
          done_cnt2++;
          check("done2_latency", cyc - last_st2, 1);
        end
        if (prev_done2) check("busy2_drop", {31'd0, bus2.busy}, 0);
        prev_done2 = bus2.done_w;
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", outs1(), 0);
    check("reset_outs2", outs2(), 0);
    rst = 1'b0;

    tbl[0] = '{syms: {2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3}, exp: 16'hE41B};
    tbl[1] = '{syms: {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}, exp: 16'h0000};
    tbl[2] = '{syms: {2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3}, exp: 16'hFFFF};
    tbl[3] = '{syms: {2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3}, exp: 16'h1B1B};
    tbl[4] = '{syms: {2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2}, exp: 16'h55AA};
    tbl[5] = '{syms: {2'd2, 2'd0, 2'd2, 2'd0, 2'd1, 2'd3, 2'd1, 2'd3}, exp: 16'h8877};
    for (int i = 0; i < 6; i++) words[i] = tbl[i].exp;
    for (int i = 6; i < 36; i++) words[i] = 16'($urandom);

    // Frame A: table vectors first, checked exactly one cycle after their last symbol
    build_exp(1'b0, 4, 16, 2);
    d0 = done_cnt;
    s0 = n_strobe;
    load_pulse();
    check("load_cnt8", {29'd0, bus.cnt_8}, 0);
    for (int i = 0; i < 6; i++) begin
      send_word(tbl[i].syms);
      check("tbl_strobe", {31'd0, bus.we_h | bus.we_s}, 1);
      check("tbl_data", {16'd0, bus.data_w}, {16'd0, tbl[i].exp});
    end
    for (int i = 6; i < 36; i++) begin
      if (i == 10) begin
        load_s = 1'b1;
        @(posedge clk); #1;
        load_s = 1'b0;
      end
      send_word(words[i]);
    end
    repeat (4) @(posedge clk);
    #1;
    check("frameA_done", done_cnt - d0, 1);
    check("frameA_strobes", n_strobe - s0, 36);
    check("frameA_queue", exp_q.size(), 0);
    check("frameA_busy", {31'd0, bus.busy}, 0);

    // Frame B: rx_en toggling every other cycle
    gap_mode = 1'b1;
    run_default_frame("frameB");
    gap_mode = 1'b0;

    // Small configuration: H0, S0 col0, S1 col0
    sel = 1'b1;
    build_exp(1'b1, 1, 2, 1);
    d0 = done_cnt2;
    load_pulse();
    for (int i = 0; i < 3; i++) send_word(words[i]);
    repeat (4) @(posedge clk);
    #1;
    check("small_done", done_cnt2 - d0, 1);
    check("small_strobes", n_strobe2, 3);
    check("small_queue", exp2_q.size(), 0);
    sel = 1'b0;

`ifdef WRITE_DATA_PARITY_EN
    // Bad check symbol: no strobe, err set, address held; then retry
    build_exp(1'b0, 4, 16, 2);
    d0 = done_cnt;
    s0 = n_strobe;
    load_pulse();
    for (int k = 0; k < 8; k++) send_sym(words[7][15-2*k -: 2]);
    send_sym(sym_xor(words[7]) ^ 2'd1);
    check("par_no_strobe", {31'd0, bus.we_h}, 0);
    check("par_err_set", {31'd0, bus.err}, 1);
    check("par_add_hold", {30'd0, bus.add_h}, 0);
    for (int i = 0; i < 36; i++) begin
      send_word(words[i]);
      if (i == 0) check("par_err_sticky", {31'd0, bus.err}, 1);
    end
    repeat (4) @(posedge clk);
    #1;
    check("par_done", done_cnt - d0, 1);
    check("par_strobes", n_strobe - s0, 36);
    check("par_err_frame_end", {31'd0, bus.err}, 1);
    load_pulse();
    check("par_err_clr_load", {31'd0, bus.err}, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
`else
    check("err_tied", {31'd0, bus.err}, 0);
`endif

    // Reset mid-frame after 5 symbols of the 3rd H word
    build_exp(1'b0, 4, 16, 2);
    load_pulse();
    send_word(words[0]);
    send_word(words[1]);
    for (int k = 0; k < 5; k++) send_sym(words[2][15-2*k -: 2]);
    check("mid_cnt8", {29'd0, bus.cnt_8}, 5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_outs", outs1(), 0);
    exp_q.delete();
    s0 = n_strobe;
    for (int c = 0; c < 1000; c++) begin
      rx_en_s = 1'b1;
      in_s    = 2'($urandom);
      @(posedge clk); #1;
    end
    rx_en_s = 1'b0;
    check("idle_no_strobes", n_strobe - s0, 0);
    check("idle_busy", {31'd0, bus.busy}, 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
